// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, funct3 access
// types, error codes, FSM states and request legality checks.
package lsu_pkg;

   localparam int MXLEN  = 32;
   localparam int BE_W   = MXLEN / 8;
   localparam int LANE_W = $clog2(BE_W);

   localparam logic [2:0] LSU_OP_LB  = 3'b000;
   localparam logic [2:0] LSU_OP_LH  = 3'b001;
   localparam logic [2:0] LSU_OP_LW  = 3'b010;
   localparam logic [2:0] LSU_OP_LBU = 3'b100;
   localparam logic [2:0] LSU_OP_LHU = 3'b101;

   localparam logic [1:0] LSU_ERR_NONE     = 2'b00;
   localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
   localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b10;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_MEM  = 2'b01,
      LSU_RESP = 2'b10
   } lsu_state_e;

   // Stores only know byte/half/word; loads reject the unused funct3 slots.
   function automatic logic is_illegal(input logic we, input logic [2:0] op);
      if (we)
         return (op != LSU_OP_LB) && (op != LSU_OP_LH) && (op != LSU_OP_LW);
      else
         return (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
   endfunction

   // Halfwords need an even address, words need a 4-byte aligned address.
   function automatic logic is_misaligned(input logic [2:0] op, input logic [LANE_W-1:0] lane);
      case (op[1:0])
         2'b01:   return lane[0];
         2'b10:   return lane != '0;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational data alignment for the load/store unit.
// The store side replicates the write data across byte lanes and builds
// byte enables; the load side extracts the addressed lane and extends it.
module lsu_align
   import lsu_pkg::*;
(
   input  logic              store_we,
   input  logic [2:0]        store_op,
   input  logic [LANE_W-1:0] store_lane,
   input  logic [MXLEN-1:0]  store_data,
   output logic [MXLEN-1:0]  store_wdata,
   output logic [BE_W-1:0]   store_be,
   input  logic [2:0]        load_op,
   input  logic [LANE_W-1:0] load_lane,
   input  logic [MXLEN-1:0]  load_word,
   output logic [MXLEN-1:0]  load_data
);

   logic [MXLEN-1:0] shifted;

   // Store formatting: replicate the data so every lane sees it, then let the byte enables pick.
   always_comb begin
      store_wdata = store_data;
      store_be    = {BE_W{1'b1}};
      if (store_we) begin
         case (store_op)
            LSU_OP_LB: begin
               store_wdata = {BE_W{store_data[7:0]}};
               store_be    = {{(BE_W-1){1'b0}}, 1'b1} << store_lane;
            end
            LSU_OP_LH: begin
               store_wdata = {(BE_W/2){store_data[15:0]}};
               store_be    = {{(BE_W-2){1'b0}}, 2'b11} << store_lane;
            end
            default: begin
               store_wdata = store_data;
               store_be    = {BE_W{1'b1}};
            end
         endcase
      end
   end

   // Load formatting: bring the addressed lane down to bit 0, then sign- or zero-extend.
   always_comb begin
      shifted = load_word >> {load_lane, 3'b000};
      case (load_op)
         LSU_OP_LB:  load_data = {{(MXLEN-8){shifted[7]}}, shifted[7:0]};
         LSU_OP_LH:  load_data = {{(MXLEN-16){shifted[15]}}, shifted[15:0]};
         LSU_OP_LBU: load_data = {{(MXLEN-8){1'b0}}, shifted[7:0]};
         LSU_OP_LHU: load_data = {{(MXLEN-16){1'b0}}, shifted[15:0]};
         default:    load_data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory operation from execute, checks it,
// runs it through a req/ack data-memory handshake and returns extended
// load data to writeback. Rejected operations never reach memory.
module lsu
   import lsu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [MXLEN-1:0]  req_addr,
   input  logic [MXLEN-1:0]  req_wdata,
   input  logic [2:0]        req_op,
   input  logic              req_we,
   input  logic [4:0]        req_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MXLEN-1:0]  mem_addr,
   output logic [MXLEN-1:0]  mem_wdata,
   output logic [BE_W-1:0]   mem_be,
   input  logic              mem_ack,
   input  logic [MXLEN-1:0]  mem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [MXLEN-1:0]  wb_data,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [MXLEN-1:0]  err_addr
);

   lsu_state_e       state_q, state_d;

   logic [MXLEN-1:0] addr_q;
   logic [MXLEN-1:0] wdata_q;
   logic [BE_W-1:0]  be_q;
   logic             we_q;
   logic [2:0]       op_q;
   logic [4:0]       rd_q;
   logic [MXLEN-1:0] wb_data_q;
   logic             done_q;
   logic             err_q;
   logic [1:0]       err_code_q;
   logic [MXLEN-1:0] err_addr_q;

   logic             accept;
   logic             err_set;
   logic [1:0]       err_code_d;
   logic             store_done;
   logic             load_capture;

   logic [MXLEN-1:0] fmt_wdata;
   logic [BE_W-1:0]  fmt_be;
   logic [MXLEN-1:0] fmt_load;

   logic             in_mem;
   logic             in_resp;

   // Store side formats the incoming request; load side works on the registered op and lane.
   lsu_align u_align (
      .store_we    (req_we),
      .store_op    (req_op),
      .store_lane  (req_addr[LANE_W-1:0]),
      .store_data  (req_wdata),
      .store_wdata (fmt_wdata),
      .store_be    (fmt_be),
      .load_op     (op_q),
      .load_lane   (addr_q[LANE_W-1:0]),
      .load_word   (mem_rdata),
      .load_data   (fmt_load)
   );

   // Next-state logic: check requests in IDLE, wait for ack in MEM, pulse writeback in RESP.
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      err_set      = 1'b0;
      err_code_d   = LSU_ERR_NONE;
      store_done   = 1'b0;
      load_capture = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (req_valid) begin
               if (is_illegal(req_we, req_op)) begin
                  err_set    = 1'b1;
                  err_code_d = LSU_ERR_ILLEGAL;
               end else if (is_misaligned(req_op, req_addr[LANE_W-1:0])) begin
                  err_set    = 1'b1;
                  err_code_d = LSU_ERR_MISALIGN;
               end else begin
                  accept  = 1'b1;
                  state_d = LSU_MEM;
               end
            end
         end
         LSU_MEM: begin
            if (mem_ack) begin
               if (we_q) begin
                  store_done = 1'b1;
                  state_d    = LSU_IDLE;
               end else begin
                  load_capture = 1'b1;
                  state_d      = LSU_RESP;
               end
            end
         end
         LSU_RESP: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   // State register; reset drops the FSM to IDLE at once, which also kills mem_req.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= LSU_IDLE;
      else
         state_q <= state_d;
   end

   // Capture the formatted transaction on accept so mem_* stay stable for the whole MEM phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         op_q    <= 3'b000;
         rd_q    <= 5'd0;
      end else if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= fmt_wdata;
         be_q    <= fmt_be;
         we_q    <= req_we;
         op_q    <= req_op;
         rd_q    <= req_rd;
      end
   end

   // Load result register; it keeps its value between writeback pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wb_data_q <= '0;
      else if (load_capture)
         wb_data_q <= fmt_load;
   end

   // Completion and error pulses for rejected requests and finished stores.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= LSU_ERR_NONE;
         err_addr_q <= '0;
      end else begin
         done_q <= err_set | store_done;
         err_q  <= err_set;
         if (err_set) begin
            err_code_q <= err_code_d;
            err_addr_q <= req_addr;
         end else begin
            err_code_q <= LSU_ERR_NONE;
            err_addr_q <= '0;
         end
      end
   end

   // Output decode; memory signals are only driven while a transaction is outstanding.
   always_comb begin
      in_mem    = (state_q == LSU_MEM);
      in_resp   = (state_q == LSU_RESP);
      req_ready = rst_n && (state_q == LSU_IDLE);
      mem_req   = in_mem;
      mem_we    = in_mem && we_q;
      mem_addr  = in_mem ? {addr_q[MXLEN-1:LANE_W], {LANE_W{1'b0}}} : '0;
      mem_wdata = in_mem ? wdata_q : '0;
      mem_be    = in_mem ? be_q : '0;
      wb_valid  = in_resp;
      wb_rd     = in_resp ? rd_q : 5'd0;
      wb_data   = wb_data_q;
      done      = done_q || in_resp;
      err       = err_q;
      err_code  = err_code_q;
      err_addr  = err_addr_q;
   end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for the load/store unit: loads with every extension,
// store formatting, rejected requests, delayed ack, stray ack and reset
// in the middle of a transaction.
module tb_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_op;
   logic        req_we;
   logic [4:0]  req_rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [31:0] err_addr;

   int compared;
   int mismatched;

   lsu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_op    (req_op),
      .req_we    (req_we),
      .req_rd    (req_rd),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .err_addr  (err_addr)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request to the LSU (valid=0 idles the request port).
   task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] op, input logic we, input logic [4:0] rd);
      req_valid = valid;
      req_addr  = addr;
      req_wdata = wdata;
      req_op    = op;
      req_we    = we;
      req_rd    = rd;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Single-cycle-ack load: accept, ack in the first MEM cycle, check the writeback pulse.
   task automatic runLoad(input string tag, input logic [31:0] addr, input logic [2:0] op,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp_data);
      applyStimulus(1'b1, addr, 32'h0, op, 1'b0, rd);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0);
      checkOutput({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
      checkOutput({tag, ".mem_be"}, {28'b0, mem_be}, 32'hF);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checkOutput({tag, ".wb_valid"}, {31'b0, wb_valid}, 32'd1);
      checkOutput({tag, ".wb_data"}, wb_data, exp_data);
      checkOutput({tag, ".wb_rd"}, {27'b0, wb_rd}, {27'b0, rd});
      checkOutput({tag, ".done"}, {31'b0, done}, 32'd1);
      tick();
      checkOutput({tag, ".idle_ready"}, {31'b0, req_ready}, 32'd1);
   endtask

   // Store with ack in the first MEM cycle: check memory-side formatting and the done pulse.
   task automatic runStore(input string tag, input logic [31:0] addr, input logic [2:0] op,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_be);
      applyStimulus(1'b1, addr, wdata, op, 1'b1, 5'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0);
      checkOutput({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
      checkOutput({tag, ".mem_we"}, {31'b0, mem_we}, 32'd1);
      checkOutput({tag, ".mem_addr"}, mem_addr, exp_addr);
      checkOutput({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
      checkOutput({tag, ".mem_be"}, {28'b0, mem_be}, {28'b0, exp_be});
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput({tag, ".done"}, {31'b0, done}, 32'd1);
      checkOutput({tag, ".no_wb"}, {31'b0, wb_valid}, 32'd0);
      checkOutput({tag, ".mem_req_off"}, {31'b0, mem_req}, 32'd0);
      checkOutput({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
      tick();
      checkOutput({tag, ".done_off"}, {31'b0, done}, 32'd0);
   endtask

   // Rejected request: error pulse next cycle, memory never requested.
   task automatic runReject(input string tag, input logic [31:0] addr, input logic [2:0] op,
                            input logic we, input logic [1:0] exp_code);
      applyStimulus(1'b1, addr, 32'h5555_5555, op, we, 5'd3);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0);
      checkOutput({tag, ".err"}, {31'b0, err}, 32'd1);
      checkOutput({tag, ".err_code"}, {30'b0, err_code}, {30'b0, exp_code});
      checkOutput({tag, ".err_addr"}, err_addr, addr);
      checkOutput({tag, ".done"}, {31'b0, done}, 32'd1);
      checkOutput({tag, ".mem_req"}, {31'b0, mem_req}, 32'd0);
      checkOutput({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
      tick();
      checkOutput({tag, ".err_off"}, {31'b0, err}, 32'd0);
      checkOutput({tag, ".mem_req_after"}, {31'b0, mem_req}, 32'd0);
   endtask

   // Directed test sequence.
   initial begin
      compared   = 0;
      mismatched = 0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'h0;
      applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      tick();
      tick();

      checkOutput("rst.req_ready", {31'b0, req_ready}, 32'd0);
      checkOutput("rst.mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("rst.wb_valid", {31'b0, wb_valid}, 32'd0);
      checkOutput("rst.wb_data", wb_data, 32'h0);
      checkOutput("rst.done", {31'b0, done}, 32'd0);
      checkOutput("rst.err", {31'b0, err}, 32'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("rst.ready_after", {31'b0, req_ready}, 32'd1);

      // LW with ack one cycle after mem_req: wb_valid three cycles after accept.
      applyStimulus(1'b1, 32'h0000_0100, 32'h0, 3'b010, 1'b0, 5'd7);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0);
      checkOutput("lw.mem_req", {31'b0, mem_req}, 32'd1);
      checkOutput("lw.mem_addr", mem_addr, 32'h0000_0100);
      checkOutput("lw.mem_be", {28'b0, mem_be}, 32'hF);
      checkOutput("lw.mem_we", {31'b0, mem_we}, 32'd0);
      checkOutput("lw.req_ready", {31'b0, req_ready}, 32'd0);
      tick();
      checkOutput("lw.mem_req_hold", {31'b0, mem_req}, 32'd1);
      checkOutput("lw.no_wb_yet", {31'b0, wb_valid}, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checkOutput("lw.wb_valid", {31'b0, wb_valid}, 32'd1);
      checkOutput("lw.wb_data", wb_data, 32'hDEAD_BEEF);
      checkOutput("lw.wb_rd", {27'b0, wb_rd}, 32'd7);
      checkOutput("lw.done", {31'b0, done}, 32'd1);
      checkOutput("lw.resp_not_ready", {31'b0, req_ready}, 32'd0);
      tick();
      checkOutput("lw.wb_off", {31'b0, wb_valid}, 32'd0);
      checkOutput("lw.wb_data_hold", wb_data, 32'hDEAD_BEEF);

      // Sub-word loads from the same word 0x80FF_FF00.
      runLoad("lb", 32'h0000_0103, 3'b000, 5'd1, 32'h80FF_FF00, 32'hFFFF_FF80);
      runLoad("lbu", 32'h0000_0103, 3'b100, 5'd2, 32'h80FF_FF00, 32'h0000_0080);
      runLoad("lh", 32'h0000_0102, 3'b001, 5'd3, 32'h80FF_FF00, 32'hFFFF_80FF);
      runLoad("lhu", 32'h0000_0100, 3'b101, 5'd4, 32'h80FF_FF00, 32'h0000_FF00);
      runLoad("lbu_rd0", 32'h0000_0101, 3'b100, 5'd0, 32'h80FF_7F00, 32'h0000_007F);

      // Store formatting.
      runStore("sb", 32'h0000_0201, 3'b000, 32'h1234_56AB, 32'h0000_0200, 32'hABAB_ABAB, 4'b0010);
      runStore("sh", 32'h0000_0202, 3'b001, 32'h0000_BEEF, 32'h0000_0200, 32'hBEEF_BEEF, 4'b1100);
      runStore("sw", 32'h0000_0300, 3'b010, 32'hCAFE_F00D, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111);
      checkOutput("store.wb_data_hold", wb_data, 32'h0000_007F);

      // Rejected requests.
      runReject("lw_mis", 32'h0000_0102, 3'b010, 1'b0, 2'b01);
      runReject("lh_mis", 32'h0000_0101, 3'b001, 1'b0, 2'b01);
      runReject("st_ill", 32'h0000_0400, 3'b100, 1'b1, 2'b10);
      runReject("ld_ill", 32'h0000_0401, 3'b011, 1'b0, 2'b10);

      // LW with ack delayed five cycles: memory side held stable.
      applyStimulus(1'b1, 32'h0000_0204, 32'h0, 3'b010, 1'b0, 5'd9);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("slow.mem_req", {31'b0, mem_req}, 32'd1);
         checkOutput("slow.mem_addr", mem_addr, 32'h0000_0204);
         checkOutput("slow.mem_be", {28'b0, mem_be}, 32'hF);
         checkOutput("slow.mem_we", {31'b0, mem_we}, 32'd0);
         checkOutput("slow.req_ready", {31'b0, req_ready}, 32'd0);
         checkOutput("slow.no_wb", {31'b0, wb_valid}, 32'd0);
         tick();
      end
      checkOutput("slow.mem_req_last", {31'b0, mem_req}, 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1122_3344;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checkOutput("slow.wb_valid", {31'b0, wb_valid}, 32'd1);
      checkOutput("slow.wb_data", wb_data, 32'h1122_3344);
      checkOutput("slow.wb_rd", {27'b0, wb_rd}, 32'd9);
      tick();

      // Stray ack while idle.
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checkOutput("stray.wb_valid", {31'b0, wb_valid}, 32'd0);
      checkOutput("stray.done", {31'b0, done}, 32'd0);
      checkOutput("stray.mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("stray.ready", {31'b0, req_ready}, 32'd1);
      checkOutput("stray.wb_data", wb_data, 32'h1122_3344);

      // Reset while in MEM: mem_req drops at once, late ack ignored.
      applyStimulus(1'b1, 32'h0000_0100, 32'h0, 3'b010, 1'b0, 5'd5);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0);
      checkOutput("rstmem.mem_req_before", {31'b0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstmem.mem_req_async", {31'b0, mem_req}, 32'd0);
      checkOutput("rstmem.ready_low", {31'b0, req_ready}, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hAAAA_AAAA;
      tick();
      rst_n = 1'b1;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checkOutput("rstmem.wb_valid", {31'b0, wb_valid}, 32'd0);
      checkOutput("rstmem.done", {31'b0, done}, 32'd0);
      checkOutput("rstmem.mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("rstmem.ready", {31'b0, req_ready}, 32'd1);

      // Normal operation resumes after the reset.
      runLoad("post_rst", 32'h0000_0108, 3'b010, 5'd12, 32'h0BAD_F00D, 32'h0BAD_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, with rs2 as store data and funct3 as the access type.
- Runs one data-memory transaction through a req/ack handshake.
- Returns sign- or zero-extended load data to writeback.
- Flags misaligned accesses and illegal access types without touching memory.

Parameters:
- MXLEN, 32, data and address width; taken from the shared defines.
- BE_W, MXLEN/8, number of byte-enable lanes.

Ports:
- clk  in  1  core clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents a memory operation.
- req_ready  out  1  LSU can accept a new operation.
- req_addr  in  MXLEN  effective address (ALU out).
- req_wdata  in  MXLEN  store data (rs2).
- req_op  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_we  in  1  1 = store, 0 = load.
- req_rd  in  5  load destination register.
- mem_req  out  1  data-memory request.
- mem_we  out  1  write strobe.
- mem_addr  out  MXLEN  word-aligned address ({req_addr[31:2],2'b00}).
- mem_wdata  out  MXLEN  lane-replicated store data.
- mem_be  out  BE_W  byte enables.
- mem_ack  in  1  memory completes the transaction; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  in  MXLEN  read word.
- wb_valid  out  1  one-cycle pulse; load result is valid.
- wb_rd  out  5  destination register.
- wb_data  out  MXLEN  extended load data.
- done  out  1  one-cycle pulse; operation retired, with or without error.
- err  out  1  one-cycle pulse; operation rejected.
- err_code  out  2  01 misaligned, 10 illegal op.
- err_addr  out  MXLEN  faulting address.

Behaviour:
- Reset: all outputs are 0 and state is IDLE; req_ready is 0 while rst_n is low.
- Reset mid-transaction:
  - mem_req drops immediately (asynchronously).
  - An ack arriving after reset is ignored.
- States: IDLE, MEM, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, the LSU checks the request combinationally.
- Illegal op in IDLE:
  - Condition: store with op not in {000,001,010}, or load with op in {011,110,111}.
  - Next cycle: err=1, err_code=10, err_addr=req_addr, done=1.
  - State stays IDLE; no memory access.
- Misaligned in IDLE:
  - Condition: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Next cycle: err=1, err_code=01, done=1.
  - State stays IDLE; no memory access.
- Legal request in IDLE:
  - Address, data, op, rd and lane are registered.
  - Next state is MEM; mem_req=1 from the next cycle.
- Store formatting:
  - SB: wdata = {4{b}}, be = 0001<<addr[1:0].
  - SH: wdata = {2{h}}, be = 0011<<addr[1:0].
  - SW: wdata as given, be = 1111.
  - Loads drive be = 1111 and mem_we = 0.
- MEM:
  - req_ready = 0.
  - mem_req and all mem_* outputs are held stable until mem_ack is sampled high; there is no timeout.
  - On ack with a load: the word is shifted right by 8*addr[1:0] and extended per op into the wb_data register. Next state is RESP.
  - On ack with a store: done=1 next cycle. Next state is IDLE.
- RESP:
  - wb_valid=1, done=1, wb_rd=rd for one cycle, then IDLE.
  - rd=0 still asserts wb_valid; the register file discards it.
- mem_ack seen in IDLE or RESP is ignored.
- req_ready is 0 in MEM and RESP.
- Throughput: one access per 3 cycles (load) or 2 cycles (store) with single-cycle ack.
- Latency: accept at cycle N, mem_req at N+1; with ack at N+1, wb_valid is at N+2.
- wb_data holds its last value between pulses.

Decomposition:
- Shared defines:
  - LSU_OP_LB/LH/LW/LBU/LHU funct3 constants.
  - LSU_ERR_MISALIGN/LSU_ERR_ILLEGAL codes.
  - State encodings LSU_IDLE/LSU_MEM/LSU_RESP.
- Sub-module lsu_align (combinational):
  - Store side: lane replication and byte-enable generation.
  - Load side: lane extraction and sign/zero extension.
  - Exercisable standalone.

Test Plan:
- LW addr=0x100, ack 1 cycle after mem_req with rdata=0xDEADBEEF → mem_be=1111, mem_addr=0x100; wb_valid with wb_data=0xDEADBEEF, wb_rd=req_rd, 3 cycles after accept.
- LB / LBU addr=0x103, rdata=0x80FF_FF00 → LB wb_data=0xFFFFFF80, LBU wb_data=0x00000080; LH addr=0x102 same word → 0xFFFF80FF.
- SB addr=0x201 wdata=0x123456AB → mem_wdata=0xABABABAB, mem_be=0010, mem_we=1; done one cycle after ack, no wb_valid.
- SH addr=0x202 wdata=0x0000BEEF → mem_wdata=0xBEEFBEEF, mem_be=1100.
- LW addr=0x102 → err=1, err_code=01, err_addr=0x102, mem_req never asserted. Store with op=100 → err_code=10.
- LW with ack delayed 5 cycles → mem_* stable throughout, req_ready=0. A stray ack in IDLE is ignored. rst_n low while in MEM → mem_req=0 immediately; after release, state is IDLE and req_ready=1.
